// File: rtl/usart_pkg.sv
// Shared usart definitions: frame geometry, bit-timer width and the transmitter/receiver state encodings.
package usart_pkg;

   localparam int unsigned USART_DATA_BITS = 8;
   localparam int unsigned USART_CNT_W     = 12;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // A divisor of zero behaves as one clock per bit.
   function automatic logic [USART_CNT_W-1:0] usart_bit_len(input logic [USART_CNT_W-1:0] cpb);
      return (cpb == '0) ? USART_CNT_W'(1) : cpb;
   endfunction

endpackage

// File: rtl/usart_tx_fifo.sv
// Synchronous FIFO with first-word fall-through read data and registered full/empty flags.
module usart_tx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic             rd,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, empty_q;
   logic             push_c, pop_c;

   // Pre-edge flags gate both sides, so a push while full is dropped even if a pop coincides.
   assign push_c = wr && !full_q;
   assign pop_c  = rd && !empty_q;

   always_comb begin
      count_d = count_q;
      if (push_c && !pop_c) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop_c && !push_c) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
         full_q  <= (count_d == CNT_W'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/usart_tx_buffered.sv
// Buffered 8N1 serial transmitter: FIFO-fed frame serialiser with a per-frame latched bit period.
module usart_tx_buffered
   import usart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                       comm_clock,
   input  logic                       reset,
   input  logic [USART_CNT_W-1:0]     clocks_per_bit,
   input  logic [USART_DATA_BITS-1:0] data_in,
   input  logic                       write,
   output logic                       full,
   output logic                       empty,
   output logic                       busy,
   output logic                       tx_pin
);

   localparam int unsigned IDX_W = $clog2(USART_DATA_BITS);

   logic [1:0]                 state_q, state_d;
   logic [USART_CNT_W-1:0]     cnt_q, cnt_d;
   logic [USART_CNT_W-1:0]     bit_len_q, bit_len_d;
   logic [USART_DATA_BITS-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]           bit_idx_q, bit_idx_d;
   logic                       tx_q, tx_d;
   logic                       busy_q, busy_d;

   logic                       fifo_rd_c;
   logic [USART_DATA_BITS-1:0] fifo_dout;
   logic                       fifo_empty;
   logic                       bit_end_c;

   usart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (USART_DATA_BITS)
   ) u_fifo (
      .clk   (comm_clock),
      .reset (reset),
      .wr    (write),
      .rd    (fifo_rd_c),
      .din   (data_in),
      .dout  (fifo_dout),
      .full  (full),
      .empty (fifo_empty)
   );

   assign bit_end_c = (cnt_q == bit_len_q - USART_CNT_W'(1));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_len_d = bit_len_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      fifo_rd_c = 1'b0;
      tx_d      = 1'b1;

      // Line level follows the state held before this edge.
      case (state_q)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_q[0];
         default:  tx_d = 1'b1;
      endcase

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_rd_c = 1'b1;
               shift_d   = fifo_dout;
               cnt_d     = '0;
               bit_len_d = usart_bit_len(clocks_per_bit);
               state_d   = ST_START;
            end
         end
         ST_START: begin
            if (bit_end_c) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = ST_DATA;
            end else begin
               cnt_d = cnt_q + USART_CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (bit_end_c) begin
               cnt_d   = '0;
               shift_d = {1'b0, shift_q[USART_DATA_BITS-1:1]};
               if (bit_idx_q == IDX_W'(USART_DATA_BITS - 1)) begin
                  bit_idx_d = '0;
                  state_d   = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + USART_CNT_W'(1);
            end
         end
         ST_STOP: begin
            // bit_idx counts stop bits here.
            if (bit_end_c) begin
               cnt_d = '0;
               if (bit_idx_q == IDX_W'(STOP_BITS - 1)) begin
                  bit_idx_d = '0;
                  state_d   = ST_IDLE;
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + USART_CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge comm_clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_len_q <= USART_CNT_W'(1);
         shift_q   <= '0;
         bit_idx_q <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_len_q <= bit_len_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   assign empty  = fifo_empty;
   assign busy   = busy_q;
   assign tx_pin = tx_q;

endmodule
